backprop_stack_unit: RTL and testbench

Training-path gradient engine for the neural-network core. It chains per-layer derivative vectors into a running error term and forms one weight-gradient vector per (layer, row) during the backward sweep. Each vector is pushed onto a LIFO stack. The weight-update stage then pops entries in reverse order, together with their layer/row tags.

---
 rtl/backprop_stack_unit_pkg.sv | 14 +
 rtl/backprop_stack_unit_q_mul.sv | 29 ++
 rtl/backprop_stack_unit.sv | 118 +++++++++++
 tb/tb_backprop_stack_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/backprop_stack_unit_pkg.sv
// Shared fixed-point constants and saturation limits for the backprop stack unit.
package backprop_stack_unit_pkg;
   localparam int DATA_SIZE = 16;
   localparam int FRAC_BITS = 8;

   // Saturation limits for a signed value of the given width.
   function automatic longint sat_max(input int width);
      return (longint'(1) <<< (width - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int width);
      return -(longint'(1) <<< (width - 1));
   endfunction
endpackage

// File: rtl/backprop_stack_unit_q_mul.sv
// Single-lane signed fixed-point multiply with arithmetic rescale and saturation.
module q_mul
   import backprop_stack_unit_pkg::*;
#(
   parameter int data_size = DATA_SIZE,
   parameter int frac_bits = FRAC_BITS
) (
   input  logic signed [data_size-1:0] a,
   input  logic signed [data_size-1:0] b,
   output logic signed [data_size-1:0] p
);
   localparam int PW = 2 * data_size;
   localparam logic signed [PW-1:0] MAX_V = PW'(sat_max(data_size));
   localparam logic signed [PW-1:0] MIN_V = PW'(sat_min(data_size));

   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] shifted;

   always_comb begin
      prod    = PW'(a) * PW'(b);
      shifted = prod >>> frac_bits;
      if (shifted > MAX_V)
         p = MAX_V[data_size-1:0];
      else if (shifted < MIN_V)
         p = MIN_V[data_size-1:0];
      else
         p = shifted[data_size-1:0];
   end
endmodule

// File: rtl/backprop_stack_unit.sv
// Backward-sweep gradient engine: chains derivatives into an error term and
// stacks one weight-gradient vector per (layer, row) for LIFO readout.
module backprop_stack_unit
   import backprop_stack_unit_pkg::*;
#(
   parameter int max_layer_size = 4,
   parameter int data_size      = DATA_SIZE,
   parameter int size           = 3,
   parameter int frac_bits      = FRAC_BITS
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [size*data_size-1:0] diff_cost,
   input  logic [size*data_size-1:0] diff_act,
   input  logic [size*data_size-1:0] diff_dense,
   input  logic [size*data_size-1:0] diff_start,
   input  logic [31:0]               current_input_layer,
   input  logic [31:0]               current_input_row,
   input  logic                      is_last_layer,
   input  logic                      start_new_layer,
   input  logic                      active_train,
   input  logic                      read_update_data,
   output logic [size*data_size-1:0] update_weight_value,
   output logic [31:0]               update_weight_layer,
   output logic [31:0]               update_weight_row,
   output logic                      is_update_weight
);
   localparam int DEPTH = max_layer_size * size;
   localparam int SP_W  = $clog2(DEPTH + 1);
   localparam int VW    = size * data_size;

   logic signed [data_size-1:0] c_reg  [size];
   logic signed [data_size-1:0] e_lane [size];
   logic signed [data_size-1:0] g_lane [size];
   logic [VW-1:0]               g_vec;

   genvar gi;
   generate
      for (gi = 0; gi < size; gi++) begin : g_lane_blk
         logic signed [data_size-1:0] cost_l, act_l, dense_l, start_l;
         logic signed [data_size-1:0] m0_a, m0_b, m0_p, m1_p;

         assign cost_l  = diff_cost [(size-gi)*data_size-1 -: data_size];
         assign act_l   = diff_act  [(size-gi)*data_size-1 -: data_size];
         assign dense_l = diff_dense[(size-gi)*data_size-1 -: data_size];
         assign start_l = diff_start[(size-gi)*data_size-1 -: data_size];

         // First multiplier is shared: cost*act on the output layer, C*dense otherwise.
         assign m0_a = is_last_layer ? cost_l : c_reg[gi];
         assign m0_b = is_last_layer ? act_l  : dense_l;

         q_mul #(.data_size(data_size), .frac_bits(frac_bits)) u_chain (
            .a(m0_a), .b(m0_b), .p(m0_p));
         q_mul #(.data_size(data_size), .frac_bits(frac_bits)) u_dense (
            .a(m0_p), .b(act_l), .p(m1_p));

         assign e_lane[gi] = !start_new_layer ? c_reg[gi] :
                             (is_last_layer ? m0_p : m1_p);

         q_mul #(.data_size(data_size), .frac_bits(frac_bits)) u_start (
            .a(e_lane[gi]), .b(start_l), .p(g_lane[gi]));

         assign g_vec[(size-gi)*data_size-1 -: data_size] = g_lane[gi];

         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               c_reg[gi] <= '0;
            else if (active_train)
               c_reg[gi] <= e_lane[gi];
         end
      end
   endgenerate

   logic [VW-1:0]   value_mem [DEPTH];
   logic [31:0]     layer_mem [DEPTH];
   logic [31:0]     row_mem   [DEPTH];
   logic [SP_W-1:0] sp_reg, sp_next, wr_idx, top_idx;
   logic            do_pop, do_push;

   always_comb begin
      top_idx = sp_reg - 1'b1;
      do_pop  = read_update_data && (sp_reg != '0);
      // A simultaneous pop frees the top slot, so a full stack can still take the push.
      do_push = active_train && (do_pop || (sp_reg != SP_W'(DEPTH)));
      wr_idx  = do_pop ? top_idx : sp_reg;
      sp_next = sp_reg;
      if (do_pop && !do_push)
         sp_next = sp_reg - 1'b1;
      else if (do_push && !do_pop)
         sp_next = sp_reg + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         value_mem[wr_idx] <= g_vec;
         layer_mem[wr_idx] <= current_input_layer;
         row_mem[wr_idx]   <= current_input_row;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp_reg              <= '0;
         update_weight_value <= '0;
         update_weight_layer <= '0;
         update_weight_row   <= '0;
         is_update_weight    <= 1'b0;
      end else begin
         sp_reg           <= sp_next;
         is_update_weight <= do_pop;
         if (do_pop) begin
            update_weight_value <= value_mem[top_idx];
            update_weight_layer <= layer_mem[top_idx];
            update_weight_row   <= row_mem[top_idx];
         end
      end
   end
endmodule

// File: tb/tb_backprop_stack_unit.sv
// Scoreboard bench for backprop_stack_unit: directed pushes/pops, monitor checks each pop.
module tb_backprop_stack_unit;
   localparam int VW = 48;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [VW-1:0] diff_cost = '0, diff_act = '0, diff_dense = '0, diff_start = '0;
   logic [31:0]   current_input_layer = '0, current_input_row = '0;
   logic          is_last_layer = 1'b0, start_new_layer = 1'b0;
   logic          active_train = 1'b0, read_update_data = 1'b0;
   logic [VW-1:0] update_weight_value;
   logic [31:0]   update_weight_layer, update_weight_row;
   logic          is_update_weight;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [VW-1:0] v;
      logic [31:0]   l;
      logic [31:0]   r;
   } exp_t;
   exp_t exp_q[$];

   backprop_stack_unit dut (
      .clk(clk), .reset(reset),
      .diff_cost(diff_cost), .diff_act(diff_act),
      .diff_dense(diff_dense), .diff_start(diff_start),
      .current_input_layer(current_input_layer),
      .current_input_row(current_input_row),
      .is_last_layer(is_last_layer), .start_new_layer(start_new_layer),
      .active_train(active_train), .read_update_data(read_update_data),
      .update_weight_value(update_weight_value),
      .update_weight_layer(update_weight_layer),
      .update_weight_row(update_weight_row),
      .is_update_weight(is_update_weight));

   always #5 clk = ~clk;

   function automatic logic [VW-1:0] vec3(input logic [15:0] a, b, c);
      return {a, b, c};
   endfunction

   // Monitor: every valid pop is matched against the oldest expected entry.
   always @(negedge clk) begin
      if (!reset && is_update_weight) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected got value=%h layer=%0d row=%0d",
                     update_weight_value, update_weight_layer, update_weight_row);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (update_weight_value !== e.v || update_weight_layer !== e.l ||
                update_weight_row !== e.r) begin
               errors++;
               $display("FAIL pop_entry got value=%h layer=%0d row=%0d want value=%h layer=%0d row=%0d",
                        update_weight_value, update_weight_layer, update_weight_row,
                        e.v, e.l, e.r);
            end else begin
               $display("pop ok value=%h layer=%0d row=%0d", e.v, e.l, e.r);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic set_push(input logic [31:0] layer, row, input logic snl, last,
                           input logic [VW-1:0] cost, act, dense, start);
      current_input_layer = layer;
      current_input_row   = row;
      start_new_layer     = snl;
      is_last_layer       = last;
      diff_cost           = cost;
      diff_act            = act;
      diff_dense          = dense;
      diff_start          = start;
      active_train        = 1'b1;
   endtask

   task automatic clear_push();
      active_train    = 1'b0;
      start_new_layer = 1'b0;
      is_last_layer   = 1'b0;
   endtask

   task automatic do_push(input logic [31:0] layer, row, input logic snl, last,
                          input logic [VW-1:0] cost, act, dense, start);
      set_push(layer, row, snl, last, cost, act, dense, start);
      @(posedge clk); #1;
      clear_push();
      $display("push layer=%0d row=%0d", layer, row);
   endtask

   task automatic do_pop(input logic [VW-1:0] v, input logic [31:0] l, r);
      exp_q.push_back('{v: v, l: l, r: r});
      read_update_data = 1'b1;
      @(posedge clk); #1;
      read_update_data = 1'b0;
   endtask

   task automatic pop_empty(input string name);
      read_update_data = 1'b1;
      @(posedge clk); #1;
      read_update_data = 1'b0;
      chk(name, 64'(is_update_weight), 64'd0);
      $display("pop on empty stack (%s)", name);
   endtask

   localparam logic [15:0] ONE = 16'h0100;

   initial begin
      logic [VW-1:0] ones, sat_v;
      ones  = vec3(ONE, ONE, ONE);
      sat_v = vec3(16'h7FFF, 16'h8000, 16'h0100);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", 64'(is_update_weight), 64'd0);
      chk("reset_value", 64'(update_weight_value), 64'd0);
      chk("reset_layer", 64'(update_weight_layer), 64'd0);
      chk("reset_row", 64'(update_weight_row), 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Last-layer seed
      do_push(2, 0, 1, 1, vec3(16'h0100, 16'h0200, 16'hFF00), ones, '0,
              vec3(16'h0080, 16'h0080, 16'h0080));
      do_pop(vec3(16'h0080, 16'h0100, 16'hFF80), 2, 0);
      @(posedge clk); #1;
      chk("valid_one_cycle", 64'(is_update_weight), 64'd0);

      // Propagation: C=(1,2,-1) -> (2,1,-1)
      do_push(2, 1, 1, 0, '0, vec3(16'h0100, 16'h0080, 16'h0100),
              vec3(16'h0200, 16'h0100, 16'h0100), ones);
      do_pop(vec3(16'h0200, 16'h0100, 16'hFF00), 2, 1);

      // LIFO order with distinct start vectors
      do_push(1, 0, 0, 0, '0, '0, '0, ones);
      do_push(1, 1, 0, 0, '0, '0, '0, vec3(16'h0080, 16'h0080, 16'h0080));
      do_push(1, 2, 0, 0, '0, '0, '0, vec3(16'h0200, 16'h0200, 16'h0200));
      do_pop(vec3(16'h0400, 16'h0200, 16'hFE00), 1, 2);
      do_pop(vec3(16'h0100, 16'h0080, 16'hFF80), 1, 1);
      do_pop(vec3(16'h0200, 16'h0100, 16'hFF00), 1, 0);
      pop_empty("lifo_fourth_pop");
      chk("hold_value", 64'(update_weight_value), 64'(vec3(16'h0200, 16'h0100, 16'hFF00)));
      chk("hold_layer", 64'(update_weight_layer), 64'd1);
      chk("hold_row", 64'(update_weight_row), 64'd0);

      // Saturation
      do_push(3, 0, 1, 1, vec3(16'h7F00, 16'h8000, 16'h0100), ones, '0, ones);
      do_pop(vec3(16'h7F00, 16'h8000, 16'h0100), 3, 0);
      do_push(3, 1, 1, 0, '0, ones, vec3(16'h0400, 16'h0200, 16'h0100), ones);
      do_pop(sat_v, 3, 1);

      // Full stack: 13 pushes, 12 survive
      for (int i = 0; i < 13; i++)
         do_push(0, i, 0, 0, '0, '0, '0, ones);
      for (int i = 11; i >= 0; i--)
         do_pop(sat_v, 0, i);
      pop_empty("full_thirteenth_pop");

      // Simultaneous push/pop at sp=2
      do_push(4, 0, 0, 0, '0, '0, '0, ones);
      do_push(4, 1, 0, 0, '0, '0, '0, ones);
      set_push(4, 9, 0, 0, '0, '0, '0, ones);
      do_pop(sat_v, 4, 1);
      clear_push();
      do_pop(sat_v, 4, 9);
      do_push(4, 5, 0, 0, '0, '0, '0, ones);
      do_pop(sat_v, 4, 5);

      // Asynchronous reset mid-stream while outputs are valid
      #6;
      reset = 1'b1;
      #1;
      chk("async_reset_valid", 64'(is_update_weight), 64'd0);
      chk("async_reset_value", 64'(update_weight_value), 64'd0);
      chk("async_reset_layer", 64'(update_weight_layer), 64'd0);
      chk("async_reset_row", 64'(update_weight_row), 64'd0);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      pop_empty("after_reset_stack_empty");

      // Push and pop together on an empty stack
      set_push(5, 7, 1, 1, ones, ones, '0, ones);
      pop_empty("push_pop_empty");
      clear_push();
      do_pop(ones, 5, 7);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
